// File: rtl/alu_operand_stage.sv
// Issue/writeback stage feeding a combinational 32-bit ALU: 32x32 register file, operand
// registers, hold counter and writeback. Define ALU_OPERAND_STAGE_FORWARD_EN for result bypass.
module alu_operand_stage #(
    parameter int unsigned ALU_CYCLES = 1,
    parameter logic [31:0] REG_INIT   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic        in_use_imm,
    input  logic [15:0] in_imm,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_out,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    localparam logic [3:0] LastCnt = 4'(ALU_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  s1_rd_q, s1_rd_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] regs_q [32];

    logic        s1_valid;
    logic        last;
    logic        accept;
    logic [31:0] src_a;
    logic [31:0] src_b;

    assign s1_valid = (state_q == StExec);
    assign last     = s1_valid && (cnt_q == LastCnt);
    assign accept   = in_valid && in_ready;

`ifdef ALU_OPERAND_STAGE_FORWARD_EN
    assign in_ready = !s1_valid || last;
`else
    logic hazard;
    assign hazard   = last && (s1_rd_q != 5'd0) &&
                      ((in_rs == s1_rd_q) || (!in_use_imm && (in_rt == s1_rd_q)));
    assign in_ready = (!s1_valid || last) && !hazard;
`endif

    always_comb begin
        src_a = (in_rs == 5'd0) ? 32'h0 : regs_q[in_rs];
        src_b = (in_rt == 5'd0) ? 32'h0 : regs_q[in_rt];
`ifdef ALU_OPERAND_STAGE_FORWARD_EN
        // The result being written this edge is not in the file yet; bypass it.
        if (last && (in_rs != 5'd0) && (s1_rd_q == in_rs)) src_a = alu_out;
        if (last && (in_rt != 5'd0) && (s1_rd_q == in_rt)) src_b = alu_out;
`endif
        if (in_use_imm) src_b = {{16{in_imm[15]}}, in_imm};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s1_rd_d    = s1_rd_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;

        if (state_q == StExec) begin
            if (last) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = s1_rd_q;
                wb_data_d  = alu_out;
                state_d    = StIdle;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end

        // An accept on the last cycle overrides the return to idle: zero-bubble issue.
        if (accept) begin
            alu_a_d  = src_a;
            alu_b_d  = src_b;
            alu_op_d = in_op;
            s1_rd_d  = in_rd;
            cnt_d    = 4'd0;
            state_d  = StExec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            s1_rd_q    <= 5'd0;
            alu_a_q    <= 32'h0;
            alu_b_q    <= 32'h0;
            alu_op_q   <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_rd_q    <= s1_rd_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= REG_INIT;
        end else if (last && (s1_rd_q != 5'd0)) begin
            regs_q[s1_rd_q] <= alu_out;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign dbg_data = (dbg_addr == 5'd0) ? 32'h0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench: one instance with ALU_CYCLES=1 and one with ALU_CYCLES=3, each driving a
// small bench-side ALU model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  in_op, in_rs, in_rt, in_rd, dbg_addr;
    logic        in_use_imm;
    logic [15:0] in_imm;

    logic        v1, r1, wbv1;
    logic [31:0] a1, b1, out1, wbd1, dbg1;
    logic [4:0]  op1, wbr1;
    logic        v3, r3, wbv3;
    logic [31:0] a3, b3, out3, wbd3, dbg3;
    logic [4:0]  op3, wbr3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            5'h01:   return a + b;
            5'h02:   return 32'hDEAD_BEEF;
            5'h03:   return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    assign out1 = alu_model(op1, a1, b1);
    assign out3 = alu_model(op3, a3, b3);

    alu_operand_stage #(.ALU_CYCLES(1), .REG_INIT(32'h0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_op(in_op), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_out(out1), .wb_valid(wbv1),
        .wb_rd(wbr1), .wb_data(wbd1), .dbg_addr(dbg_addr), .dbg_data(dbg1)
    );

    alu_operand_stage #(.ALU_CYCLES(3), .REG_INIT(32'h0)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .in_op(in_op), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_out(out3), .wb_valid(wbv3),
        .wb_rd(wbr3), .wb_data(wbd3), .dbg_addr(dbg_addr), .dbg_data(dbg3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; v1 = 1'b0; v3 = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_use_imm = 1'b0; in_imm = '0;
        dbg_addr = '0;
        step(); step();
        rst = 1'b0;

        chk("rst_alu_a1", a1, 0);  chk("rst_alu_b1", b1, 0);  chk("rst_alu_op1", op1, 0);
        chk("rst_wbv1", wbv1, 0);  chk("rst_alu_a3", a3, 0);  chk("rst_wbv3", wbv3, 0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk("rst_dbg1", dbg1, 0);
            chk("rst_dbg3", dbg3, 0);
        end

        // r3 = 0 + imm 2, then r4 = r3 + r3 (dependent).
        v1 = 1'b1; in_op = 5'h01; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd3;
        in_use_imm = 1'b1; in_imm = 16'd2;
        #1 chk("rdy_first", r1, 1);
        step();
        chk("i1_alu_a", a1, 0); chk("i1_alu_b", b1, 2); chk("i1_alu_op", op1, 5'h01);
        in_rs = 5'd3; in_rt = 5'd3; in_rd = 5'd4; in_use_imm = 1'b0;
        #1;
`ifdef ALU_OPERAND_STAGE_FORWARD_EN
        chk("dep_rdy_fwd", r1, 1);
        step();
        chk("wb1_valid", wbv1, 1); chk("wb1_rd", wbr1, 3); chk("wb1_data", wbd1, 2);
        chk("dep_alu_a", a1, 2); chk("dep_alu_b", b1, 2);
        v1 = 1'b0;
        #1 chk("dep_rdy_after", r1, 1);
        step();
`else
        chk("dep_rdy_stall", r1, 0);
        step();
        chk("wb1_valid", wbv1, 1); chk("wb1_rd", wbr1, 3); chk("wb1_data", wbd1, 2);
        chk("dep_rdy_retry", r1, 1);
        step();
        chk("bubble_wbv", wbv1, 0); chk("dep_alu_a", a1, 2); chk("dep_alu_b", b1, 2);
        v1 = 1'b0;
        step();
`endif
        chk("wb2_valid", wbv1, 1); chk("wb2_rd", wbr1, 4); chk("wb2_data", wbd1, 4);
        dbg_addr = 5'd4; #1 chk("dbg_r4", dbg1, 4);
        dbg_addr = 5'd3; #1 chk("dbg_r3", dbg1, 2);

        // Negative immediate sign extension.
        v1 = 1'b1; in_op = 5'h03; in_rs = 5'd4; in_use_imm = 1'b1; in_imm = 16'hFFFE;
        in_rd = 5'd5;
        step();
        chk("sext_alu_a", a1, 4); chk("sext_alu_b", b1, 32'hFFFF_FFFE);
        v1 = 1'b0;
        step();
        chk("sext_wbv", wbv1, 1); chk("sext_wbd", wbd1, 32'hFFFF_FFFA);
        dbg_addr = 5'd5; #1 chk("dbg_r5", dbg1, 32'hFFFF_FFFA);

        // rd = 0: pulse still fires, reg 0 stays 0.
        v1 = 1'b1; in_op = 5'h02; in_rs = 5'd0; in_rd = 5'd0; in_imm = 16'd0;
        step();
        v1 = 1'b0;
        step();
        chk("rd0_wbv", wbv1, 1); chk("rd0_wbr", wbr1, 0); chk("rd0_wbd", wbd1, 32'hDEAD_BEEF);
        dbg_addr = 5'd0; #1 chk("dbg_r0", dbg1, 0);

        // ALU_CYCLES=3: seed r1 = 9.
        v3 = 1'b1; in_op = 5'h01; in_rs = 5'd0; in_use_imm = 1'b1; in_imm = 16'd9;
        in_rd = 5'd1;
        step();
        v3 = 1'b0;
        step(); step(); step();
        chk("c3_seed_wbv", wbv3, 1); chk("c3_seed_wbd", wbd3, 9);
        dbg_addr = 5'd1; #1 chk("c3_dbg_r1", dbg3, 9);

        // Stream r6 = r1 + 7 with in_valid held high.
        in_rs = 5'd1; in_imm = 16'd7; in_rd = 5'd6; v3 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("c3_alu_a", a3, 9);
            chk("c3_alu_b", b3, 7);
            chk("c3_wbv", wbv3, (k > 0 && k % 3 == 0) ? 1 : 0);
            if (k > 0 && k % 3 == 0) chk("c3_wbd", wbd3, 16);
            chk("c3_rdy", r3, (k % 3 == 2) ? 1 : 0);
        end
        v3 = 1'b0;
        step();
        chk("c3_last_wbv", wbv3, 1); chk("c3_last_wbd", wbd3, 16);
        dbg_addr = 5'd6; #1 chk("c3_dbg_r6", dbg3, 16);

        // Reset while cnt=1: the held op is abandoned.
        in_rs = 5'd0; in_imm = 16'd5; in_rd = 5'd7; v3 = 1'b1;
        step();
        v3 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_wbv", wbv3, 0); chk("rst_mid_alu_a", a3, 0); chk("rst_mid_rdy", r3, 1);
        step();
        chk("rst_mid_wbv_1", wbv3, 0);
        step();
        chk("rst_mid_wbv_2", wbv3, 0);
        dbg_addr = 5'd7; #1 chk("rst_mid_dbg_r7", dbg3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
